// File: rtl/y86_pkg.sv
// Y86-64 shared constants and the decode helper used by the decode stage.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    // Values loaded into E when a bubble is inserted
    localparam logic [3:0] BUB_ICODE = INOP;
    localparam logic [3:0] BUB_IFUN  = 4'h0;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } dec_ids_t;

    // Register IDs read and written by an instruction; RNONE where unused.
    // Conditional-move cancellation happens in execute, so dst_e is unconditional here.
    function automatic dec_ids_t decode_ids(input logic [3:0] icode, input logic [3:0] ra,
                                            input logic [3:0] rb);
        dec_ids_t d;
        d = {RNONE, RNONE, RNONE, RNONE};
        case (icode)
            IRRMOVQ: begin d.src_a = ra;   d.dst_e = rb; end
            IIRMOVQ: begin d.dst_e = rb; end
            IRMMOVQ: begin d.src_a = ra;   d.src_b = rb; end
            IMRMOVQ: begin d.src_b = rb;   d.dst_m = ra; end
            IOPQ:    begin d.src_a = ra;   d.src_b = rb;   d.dst_e = rb; end
            ICALL:   begin d.src_b = RRSP; d.dst_e = RRSP; end
            IRET:    begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; end
            IPUSHQ:  begin d.src_a = ra;   d.src_b = RRSP; d.dst_e = RRSP; end
            IPOPQ:   begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; d.dst_m = ra; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_y86.sv
// Y86-64 register file: 15 entries, two combinational reads, two clocked writes.
module regfile_y86 #(
    parameter int unsigned        WORD_W  = 64,
    parameter logic [WORD_W-1:0]  SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        src_a_i,
    input  logic [3:0]        src_b_i,
    output logic [WORD_W-1:0] val_a_o,
    output logic [WORD_W-1:0] val_b_o,
    input  logic [3:0]        dst_e_i,
    input  logic [WORD_W-1:0] val_e_i,
    input  logic [3:0]        dst_m_i,
    input  logic [WORD_W-1:0] val_m_i
);
    import y86_pkg::*;

    logic [WORD_W-1:0] regs_q [15];
    logic [WORD_W-1:0] regs_d [15];

    // Read ports; RNONE reads as zero
    always_comb begin
        val_a_o = (src_a_i == RNONE) ? '0 : regs_q[src_a_i];
        val_b_o = (src_b_i == RNONE) ? '0 : regs_q[src_b_i];
    end

    // Write ports; M applied last so it wins when both target the same register
    always_comb begin
        regs_d = regs_q;
        if (dst_e_i != RNONE) regs_d[dst_e_i] = val_e_i;
        if (dst_m_i != RNONE) regs_d[dst_m_i] = val_m_i;
    end

    // Register state with async reset; %rsp gets its own initial value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == 4) ? SP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/decode_ereg_pipe.sv
// Y86-64 decode stage with forwarding, load-use detection and the D->E pipeline register.
module decode_ereg_pipe #(
    parameter int unsigned        WORD_W  = 64,
    parameter logic [WORD_W-1:0]  SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [WORD_W-1:0] D_valC,
    input  logic [WORD_W-1:0] D_valP,
    input  logic [3:0]        e_dstE,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [WORD_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [WORD_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [WORD_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [WORD_W-1:0] W_valM,
    input  logic              E_bubble,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic              load_use,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [WORD_W-1:0] E_valC,
    output logic [WORD_W-1:0] E_valA,
    output logic [WORD_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB
);
    import y86_pkg::*;

    dec_ids_t          dec;
    logic [WORD_W-1:0] rf_val_a, rf_val_b;
    logic [WORD_W-1:0] d_val_a, d_val_b;

    logic [3:0]        e_icode_q, e_icode_d, e_ifun_q, e_ifun_d;
    logic [WORD_W-1:0] e_valc_q, e_valc_d, e_vala_q, e_vala_d, e_valb_q, e_valb_d;
    logic [3:0]        e_dste_q, e_dste_d, e_dstm_q, e_dstm_d;
    logic [3:0]        e_srca_q, e_srca_d, e_srcb_q, e_srcb_d;

    assign dec    = decode_ids(D_icode, D_rA, D_rB);
    assign d_srcA = dec.src_a;
    assign d_srcB = dec.src_b;

    regfile_y86 #(
        .WORD_W  (WORD_W),
        .SP_INIT (SP_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .src_a_i (dec.src_a),
        .src_b_i (dec.src_b),
        .val_a_o (rf_val_a),
        .val_b_o (rf_val_b),
        .dst_e_i (W_dstE),
        .val_e_i (W_valE),
        .dst_m_i (W_dstM),
        .val_m_i (W_valM)
    );

    // valA: valP for call/jump, else youngest in-flight producer, else regfile
    always_comb begin
        if (D_icode == ICALL || D_icode == IJXX) d_val_a = D_valP;
        else if (dec.src_a == RNONE)             d_val_a = '0;
        else if (dec.src_a == e_dstE)            d_val_a = e_valE;
        else if (dec.src_a == M_dstM)            d_val_a = m_valM;
        else if (dec.src_a == M_dstE)            d_val_a = M_valE;
        else if (dec.src_a == W_dstM)            d_val_a = W_valM;
        else if (dec.src_a == W_dstE)            d_val_a = W_valE;
        else                                     d_val_a = rf_val_a;
    end

    // valB: same forwarding priority, no valP path
    always_comb begin
        if (dec.src_b == RNONE)       d_val_b = '0;
        else if (dec.src_b == e_dstE) d_val_b = e_valE;
        else if (dec.src_b == M_dstM) d_val_b = m_valM;
        else if (dec.src_b == M_dstE) d_val_b = M_valE;
        else if (dec.src_b == W_dstM) d_val_b = W_valM;
        else if (dec.src_b == W_dstE) d_val_b = W_valE;
        else                          d_val_b = rf_val_b;
    end

    // Load in execute whose result is needed by the instruction being decoded
    assign load_use = (e_icode_q == IMRMOVQ || e_icode_q == IPOPQ) && (e_dstm_q != RNONE) &&
                      (e_dstm_q == dec.src_a || e_dstm_q == dec.src_b);

    // E next state: decoded values, or a NOP bubble when requested
    always_comb begin
        e_icode_d = D_icode;
        e_ifun_d  = D_ifun;
        e_valc_d  = D_valC;
        e_vala_d  = d_val_a;
        e_valb_d  = d_val_b;
        e_dste_d  = dec.dst_e;
        e_dstm_d  = dec.dst_m;
        e_srca_d  = dec.src_a;
        e_srcb_d  = dec.src_b;
        if (E_bubble) begin
            e_icode_d = BUB_ICODE;
            e_ifun_d  = BUB_IFUN;
            e_valc_d  = '0;
            e_vala_d  = '0;
            e_valb_d  = '0;
            e_dste_d  = RNONE;
            e_dstm_d  = RNONE;
            e_srca_d  = RNONE;
            e_srcb_d  = RNONE;
        end
    end

    // E pipeline register; reset state is a NOP bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_icode_q <= BUB_ICODE;
            e_ifun_q  <= BUB_IFUN;
            e_valc_q  <= '0;
            e_vala_q  <= '0;
            e_valb_q  <= '0;
            e_dste_q  <= RNONE;
            e_dstm_q  <= RNONE;
            e_srca_q  <= RNONE;
            e_srcb_q  <= RNONE;
        end else begin
            e_icode_q <= e_icode_d;
            e_ifun_q  <= e_ifun_d;
            e_valc_q  <= e_valc_d;
            e_vala_q  <= e_vala_d;
            e_valb_q  <= e_valb_d;
            e_dste_q  <= e_dste_d;
            e_dstm_q  <= e_dstm_d;
            e_srca_q  <= e_srca_d;
            e_srcb_q  <= e_srcb_d;
        end
    end

    assign E_icode = e_icode_q;
    assign E_ifun  = e_ifun_q;
    assign E_valC  = e_valc_q;
    assign E_valA  = e_vala_q;
    assign E_valB  = e_valb_q;
    assign E_dstE  = e_dste_q;
    assign E_dstM  = e_dstm_q;
    assign E_srcA  = e_srca_q;
    assign E_srcB  = e_srcb_q;

endmodule

// File: tb/tb_decode_ereg_pipe.sv
// Self-checking bench for decode_ereg_pipe: directed table, corner sequences, random vs model.
module tb_decode_ereg_pipe;

    localparam logic [63:0] SP = 64'h1000;
    localparam logic [3:0]  NO = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic        load_use;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    int n_chk  = 0;
    int n_pass = 0;

    decode_ereg_pipe #(.WORD_W(64), .SP_INIT(SP)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .E_bubble(E_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA),
        .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } e_t;

    logic [63:0] m_regs [15];
    e_t          me;

    function automatic e_t nop_e();
        e_t r;
        r = '{icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
              dstE: NO, dstM: NO, srcA: NO, srcB: NO};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? SP : 64'h0;
        me = nop_e();
    endtask

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return NO;
    endfunction
    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return NO;
    endfunction
    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return NO;
    endfunction
    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return NO;
    endfunction

    // Value seen for a source: newest pipeline producer first, then architectural state
    function automatic logic [63:0] m_read(input logic [3:0] src);
        logic [3:0]  ids [5];
        logic [63:0] vals [5];
        if (src == NO) return 64'h0;
        ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        for (int k = 0; k < 5; k++) if (ids[k] == src) return vals[k];
        return m_regs[src];
    endfunction

    function automatic logic m_load_use();
        logic [3:0] sa, sb;
        sa = m_srcA(D_icode, D_rA);
        sb = m_srcB(D_icode, D_rB);
        return (me.icode inside {4'h5, 4'hB}) && me.dstM != NO && (me.dstM == sa || me.dstM == sb);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = NO; D_rB = NO; D_valC = 64'h0; D_valP = 64'h0;
        e_dstE = NO; M_dstE = NO; M_dstM = NO; W_dstE = NO; W_dstM = NO;
        e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
        E_bubble = 1'b0;
    endtask

    // Clock one edge with current inputs, advancing the model alongside
    task automatic step();
        e_t nx;
        nx.icode = D_icode; nx.ifun = D_ifun; nx.valC = D_valC;
        nx.srcA  = m_srcA(D_icode, D_rA); nx.srcB = m_srcB(D_icode, D_rB);
        nx.dstE  = m_dstE(D_icode, D_rB); nx.dstM = m_dstM(D_icode, D_rA);
        nx.valA  = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_read(nx.srcA);
        nx.valB  = m_read(nx.srcB);
        @(posedge clk);
        #1;
        if (W_dstE != NO) m_regs[W_dstE] = W_valE;
        if (W_dstM != NO) m_regs[W_dstM] = W_valM;
        me = E_bubble ? nop_e() : nx;
    endtask

    task automatic cmp_model();
        chk("rnd_E_icode", {60'h0, E_icode}, {60'h0, me.icode});
        chk("rnd_E_ifun",  {60'h0, E_ifun},  {60'h0, me.ifun});
        chk("rnd_E_valC",  E_valC, me.valC);
        chk("rnd_E_valA",  E_valA, me.valA);
        chk("rnd_E_valB",  E_valB, me.valB);
        chk("rnd_E_ids",   {48'h0, E_dstE, E_dstM, E_srcA, E_srcB},
                           {48'h0, me.dstE, me.dstM, me.srcA, me.srcB});
    endtask

    function automatic logic [3:0] rnd_id();
        int r;
        r = $urandom_range(0, 7);
        if (r < 2) return NO;
        if (r < 3) return 4'($urandom_range(0, 14));
        return 4'($urandom_range(0, 7));
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  icode, ra, rb;
        logic [63:0] valp;
        logic [3:0]  xsa, xsb, xde, xdm;
        logic [63:0] xva, xvb;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{4'h1, 4'h2, 4'h3, 64'h10, NO,   NO,   NO,   NO,   64'h0,  64'h0};
        vecs[1]  = '{4'h2, 4'h1, 4'h2, 64'h12, 4'h1, NO,   4'h2, NO,   64'h0,  64'h0};
        vecs[2]  = '{4'h3, NO,   4'h5, 64'h1a, NO,   NO,   4'h5, NO,   64'h0,  64'h0};
        vecs[3]  = '{4'h4, 4'h4, 4'h6, 64'h24, 4'h4, 4'h6, NO,   NO,   SP,     64'h0};
        vecs[4]  = '{4'h5, 4'h7, 4'h4, 64'h2e, NO,   4'h4, NO,   4'h7, 64'h0,  SP};
        vecs[5]  = '{4'h6, 4'h4, 4'h4, 64'h30, 4'h4, 4'h4, 4'h4, NO,   SP,     SP};
        vecs[6]  = '{4'h7, NO,   NO,   64'h33, NO,   NO,   NO,   NO,   64'h33, 64'h0};
        vecs[7]  = '{4'h8, NO,   NO,   64'h40, NO,   4'h4, 4'h4, NO,   64'h40, SP};
        vecs[8]  = '{4'h9, NO,   NO,   64'h41, 4'h4, 4'h4, 4'h4, NO,   SP,     SP};
        vecs[9]  = '{4'hA, 4'h3, NO,   64'h43, 4'h3, 4'h4, 4'h4, NO,   64'h0,  SP};
        vecs[10] = '{4'hB, 4'h8, NO,   64'h45, 4'h4, 4'h4, 4'h4, 4'h8, SP,     SP};
        vecs[11] = '{4'h0, 4'h1, 4'h2, 64'h46, NO,   NO,   NO,   NO,   64'h0,  64'h0};

        // Reset state
        rst = 1'b1;
        idle();
        model_reset();
        #3;
        chk("rst_E_icode", {60'h0, E_icode}, 64'h1);
        chk("rst_E_ids", {48'h0, E_dstE, E_dstM, E_srcA, E_srcB}, 64'hFFFF);
        chk("rst_E_valA", E_valA, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Decode table against fresh register file
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle();
            D_icode = vecs[i].icode; D_ifun = 4'(i); D_rA = vecs[i].ra; D_rB = vecs[i].rb;
            D_valP = vecs[i].valp; D_valC = 64'hC000 + 64'(i);
            #1;
            chk($sformatf("vec%0d_d_srcs", i), {56'h0, d_srcA, d_srcB},
                {56'h0, vecs[i].xsa, vecs[i].xsb});
            step();
            chk($sformatf("vec%0d_E_icode", i), {56'h0, E_icode, E_ifun},
                {56'h0, vecs[i].icode, 4'(i)});
            chk($sformatf("vec%0d_E_valC", i), E_valC, 64'hC000 + 64'(i));
            chk($sformatf("vec%0d_E_ids", i), {48'h0, E_srcA, E_srcB, E_dstE, E_dstM},
                {48'h0, vecs[i].xsa, vecs[i].xsb, vecs[i].xde, vecs[i].xdm});
            chk($sformatf("vec%0d_E_valA", i), E_valA, vecs[i].xva);
            chk($sformatf("vec%0d_E_valB", i), E_valB, vecs[i].xvb);
        end

        // Regfile write then read: reg3 <- 0x55, OPQ rA=rB=3 reads it back
        @(negedge clk); idle(); W_dstE = 4'h3; W_valE = 64'h55;
        step();
        @(negedge clk); idle(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h3;
        step();
        chk("wb_read_valA", E_valA, 64'h55);
        chk("wb_read_valB", E_valB, 64'h55);

        // Forward priority: execute beats memory
        @(negedge clk); idle(); D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h2;
        e_dstE = 4'h2; e_valE = 64'hA; M_dstE = 4'h2; M_valE = 64'hB;
        step();
        chk("fwd_prio_valA", E_valA, 64'hA);
        chk("fwd_prio_valB", E_valB, 64'hA);

        // Load-use detection and bubble insertion
        @(negedge clk); idle(); D_icode = 4'h5; D_rA = 4'h5; D_rB = NO;
        step();
        @(negedge clk); idle(); D_icode = 4'h6; D_rA = 4'h5; D_rB = 4'h1; E_bubble = 1'b1;
        #1;
        chk("load_use_set", {63'h0, load_use}, 64'h1);
        step();
        chk("bubble_E_icode", {60'h0, E_icode}, 64'h1);
        chk("bubble_E_ids", {48'h0, E_dstE, E_dstM, E_srcA, E_srcB}, 64'hFFFF);
        chk("load_use_clear", {63'h0, load_use}, 64'h0);

        // Both write ports target reg7: M port wins
        @(negedge clk); idle(); W_dstE = 4'h7; W_valE = 64'h1; W_dstM = 4'h7; W_valM = 64'h2;
        step();
        @(negedge clk); idle(); D_icode = 4'h2; D_rA = 4'h7; D_rB = 4'h1;
        step();
        chk("wb_m_wins", E_valA, 64'h2);

        // Writeback still lands during a bubble
        @(negedge clk); idle(); W_dstM = 4'h9; W_valM = 64'h99; E_bubble = 1'b1;
        step();
        @(negedge clk); idle(); D_icode = 4'h4; D_rA = 4'h9; D_rB = NO;
        step();
        chk("wb_during_bubble", E_valA, 64'h99);

        // Mid-cycle async reset clears E and the register file
        @(negedge clk); idle(); D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h3;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_E_icode", {60'h0, E_icode}, 64'h1);
        chk("midrst_E_dstE", {60'h0, E_dstE}, 64'hF);
        model_reset();
        @(negedge clk); rst = 1'b0; idle(); D_icode = 4'hB; D_rA = 4'h3;
        step();
        chk("midrst_rsp_init", E_valA, SP);
        @(negedge clk); idle(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h7;
        step();
        chk("midrst_reg3_clr", E_valA, 64'h0);
        chk("midrst_reg7_clr", E_valB, 64'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom_range(0, 15));
            D_rA = rnd_id(); D_rB = rnd_id();
            D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
            e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
            W_dstE = rnd_id(); W_dstM = rnd_id();
            e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
            m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            E_bubble = ($urandom_range(0, 7) == 0);
            #1;
            chk("rnd_d_srcs", {56'h0, d_srcA, d_srcB},
                {56'h0, m_srcA(D_icode, D_rA), m_srcB(D_icode, D_rB)});
            chk("rnd_load_use", {63'h0, load_use}, {63'h0, m_load_use()});
            step();
            cmp_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
